bcd_conv_scheduler: RTL and testbench

BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

---
 rtl/bcd_conv_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_conv_scheduler
//
// Purpose: shares one serial binary-to-BCD converter (double dabble, one bit per
// clock) between NUM_REQ requesters. In IDLE an arbiter picks one requester and
// captures its operand. The shift-add datapath then runs for BIN_W CONV cycles.
// A single DONE cycle loads the result registers, and the result appears on the
// outputs in the following cycle.
//
// Handshake: req_ip[k] is a level request, sampled only while IDLE. The grant is
// signalled by a one-cycle ack_op[k] pulse in the cycle after capture. The
// requester drops req_ip[k] in that cycle. A request still high in the next IDLE
// cycle counts as a new request. res_valid_op is a one-cycle pulse with
// res_id_op/bcd_data_op valid alongside it. The result registers hold until the
// next completion.
//
// Timing: ack -> res_valid is BIN_W+1 cycles. Grants to continuously waiting
// requesters are BIN_W+2 cycles apart, because the arbiter samples during the
// result cycle.
//
// Configuration: define BCD_FIXED_PRIO_EN for fixed priority (requester 0
// highest, no pointer). Otherwise arbitration is round-robin from pointer p.
//
// Ports:
//   clk_1mhz       in   clock, rising edge active
//   reset_n_ip     in   asynchronous active-low reset
//   req_ip         in   [NUM_REQ]        request levels
//   binary_data_ip in   [NUM_REQ*BIN_W]  operands, requester k at [k*BIN_W +: BIN_W]
//   ack_op         out  [NUM_REQ]        capture pulse for the granted requester
//   busy_op        out  high in CONV and DONE
//   res_valid_op   out  one-cycle result pulse
//   res_id_op      out  [3]  owner of the result
//   bcd_data_op    out  [16] {thousands, hundreds, tens, units}
//   state_dbg      out  [2]  current FSM state (0 IDLE, 1 CONV, 2 DONE)
// -----------------------------------------------------------------------------
module bcd_conv_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 13
) (
    input  logic                     clk_1mhz,
    input  logic                     reset_n_ip,
    input  logic [NUM_REQ-1:0]       req_ip,
    input  logic [NUM_REQ*BIN_W-1:0] binary_data_ip,
    output logic [NUM_REQ-1:0]       ack_op,
    output logic                     busy_op,
    output logic                     res_valid_op,
    output logic [2:0]               res_id_op,
    output logic [15:0]              bcd_data_op,
    output logic [1:0]               state_dbg
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [BIN_W-1:0] operand;
    logic [15:0]      digits;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       cur_id;

    logic             grant_any;
    logic [2:0]       grant_idx;
    logic [BIN_W-1:0] grant_operand;
    logic [15:0]      dabble_next;

    assign state_dbg = state;

`ifdef BCD_FIXED_PRIO_EN
    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_ip[j]) begin
                grant_any = 1'b1;
                grant_idx = 3'(j);
            end
        end
    end
`else
    logic [2:0]           rr_ptr;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [2:0]           sel_off;
    logic [3:0]           grant_sum;
    logic [3:0]           ptr_next;

    // Rotate the requests so bit 0 is requester p. The first set bit is then
    // the offset of the winner from the pointer.
    always_comb begin
        req_dbl   = {req_ip, req_ip};
        req_rot   = req_dbl[rr_ptr +: NUM_REQ];
        grant_any = 1'b0;
        sel_off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                grant_any = 1'b1;
                sel_off   = 3'(j);
            end
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
        if (grant_sum >= 4'(NUM_REQ)) begin
            grant_sum = grant_sum - 4'(NUM_REQ);
        end
        grant_idx = grant_sum[2:0];
        ptr_next  = {1'b0, grant_idx} + 4'd1;
        if (ptr_next >= 4'(NUM_REQ)) begin
            ptr_next = '0;
        end
    end
`endif

    always_comb begin
        grant_operand = binary_data_ip[grant_idx*BIN_W +: BIN_W];
    end

    // One double-dabble step: correct each digit that would overflow past 9
    // when doubled, then shift the operand MSB into the units LSB. The carry
    // out of the thousands digit is dropped, which leaves the result mod 10000.
    always_comb begin
        logic [15:0] adj;
        adj = '0;
        for (int d = 0; d < 4; d++) begin
            adj[d*4 +: 4] = (digits[d*4 +: 4] >= 4'd5) ? digits[d*4 +: 4] + 4'd3
                                                         : digits[d*4 +: 4];
        end
        dabble_next = {adj[14:0], operand[BIN_W-1]};
    end

    always_ff @(posedge clk_1mhz or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            state        <= IDLE;
            operand      <= '0;
            digits       <= '0;
            bit_cnt      <= '0;
            cur_id       <= '0;
            ack_op       <= '0;
            busy_op      <= 1'b0;
            res_valid_op <= 1'b0;
            res_id_op    <= '0;
            bcd_data_op  <= '0;
`ifndef BCD_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
        end else begin
            ack_op       <= '0;
            res_valid_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        operand <= grant_operand;
                        cur_id  <= grant_idx;
                        digits  <= '0;
                        bit_cnt <= '0;
                        ack_op  <= NUM_REQ'(1) << grant_idx;
                        busy_op <= 1'b1;
                        state   <= CONV;
`ifndef BCD_FIXED_PRIO_EN
                        rr_ptr  <= ptr_next[2:0];
`endif
                    end
                end
                CONV: begin
                    digits  <= dabble_next;
                    operand <= {operand[BIN_W-2:0], 1'b0};
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bcd_data_op  <= digits;
                    res_id_op    <= cur_id;
                    res_valid_op <= 1'b1;
                    busy_op      <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy_op <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_scheduler
//
// Requesters raise levels and drop them on ack. The monitor predicts each grant
// from the requests sampled at the grant edge. It pushes the expected
// {id, bcd} into exp_q and pops it when res_valid_op appears. Directed
// sequences cover the example cases, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_bcd_conv_scheduler;
  localparam int NUM_REQ = 4;
  localparam int BIN_W   = 13;
  localparam int LAT     = BIN_W + 1;

  // clock / reset
  logic clk_1mhz   = 1'b0;
  logic reset_n_ip = 1'b1;
  initial forever #500 clk_1mhz = ~clk_1mhz;

  logic [NUM_REQ-1:0]       req_ip = '0;
  logic [NUM_REQ*BIN_W-1:0] binary_data_ip = '0;
  logic [NUM_REQ-1:0]       ack_op;
  logic                     busy_op;
  logic                     res_valid_op;
  logic [2:0]               res_id_op;
  logic [15:0]              bcd_data_op;
  logic [1:0]               state_dbg;

  bcd_conv_scheduler #(.NUM_REQ(NUM_REQ), .BIN_W(BIN_W)) dut (
    .clk_1mhz       (clk_1mhz),
    .reset_n_ip     (reset_n_ip),
    .req_ip         (req_ip),
    .binary_data_ip (binary_data_ip),
    .ack_op         (ack_op),
    .busy_op        (busy_op),
    .res_valid_op   (res_valid_op),
    .res_id_op      (res_id_op),
    .bcd_data_op    (bcd_data_op),
    .state_dbg      (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  int model_ptr = 0;

  function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
    int start;
`ifdef BCD_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      if (m[(start + off) % NUM_REQ]) return (start + off) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  // scoreboard
  logic [18:0] exp_q[$];
  int          due_q[$];
  int          grant_log[$];

  // requester driver state (written by the initial block only)
  int               raise_seq[NUM_REQ];
  logic [BIN_W-1:0] pend_data[NUM_REQ];
  logic [BIN_W-1:0] alt_data[NUM_REQ];
  logic [NUM_REQ-1:0] hold_mode = '0;
  logic [NUM_REQ-1:0] alt_en    = '0;
  // written by the requester process only
  int               served_seq[NUM_REQ];

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      raise_seq[k] = 0;
      served_seq[k] = 0;
      pend_data[k] = '0;
      alt_data[k] = '0;
    end
  end

  // samples at the active edge, what the DUT sees
  logic [NUM_REQ-1:0]       req_prev  = '0;
  logic [NUM_REQ*BIN_W-1:0] data_prev = '0;
  always @(posedge clk_1mhz) begin
    cyc++;
    req_prev  = req_ip;
    data_prev = binary_data_ip;
  end

  // requesters: drop on ack (optionally change operand), raise when asked
  always @(posedge clk_1mhz) begin
    #100;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ack_op[k]) begin
        req_ip[k] = 1'b0;
        if (alt_en[k]) binary_data_ip[k*BIN_W +: BIN_W] = alt_data[k];
      end else if (!req_ip[k] && raise_seq[k] != served_seq[k]) begin
        binary_data_ip[k*BIN_W +: BIN_W] = pend_data[k];
        req_ip[k] = 1'b1;
        served_seq[k] = raise_seq[k];
      end else if (!req_ip[k] && hold_mode[k]) begin
        req_ip[k] = 1'b1;
      end
    end
  end

  // monitor
  logic        busy_last = 1'b0;
  logic        expect_ack;
  int          w;
  int          d;
  logic [18:0] e;
  always @(negedge clk_1mhz) begin
    if (!reset_n_ip) begin
      busy_last = 1'b0;
    end else begin
      expect_ack = !busy_last && (req_prev != '0);
      chk("ack_timing", 32'(ack_op != '0), 32'(expect_ack));
      if (ack_op != '0) begin
        w = pick(req_prev, model_ptr);
        chk("ack_grant", 32'(ack_op), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("busy_at_ack", 32'(busy_op), 32'd1);
        if (w >= 0) begin
          exp_q.push_back({3'(w), to_bcd(int'(data_prev[w*BIN_W +: BIN_W]))});
          due_q.push_back(cyc + LAT);
          grant_log.push_back(w);
          model_ptr = (w + 1) % NUM_REQ;
        end
      end
      if (res_valid_op) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 32'(res_valid_op), 32'd0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("res_data", 32'({res_id_op, bcd_data_op}), 32'(e));
          chk("res_latency", cyc, d);
        end
      end else if (due_q.size() != 0 && cyc >= due_q[0]) begin
        chk("res_missing", cyc, due_q[0] - 1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      busy_last = busy_op;
    end
  end

  // driver tasks
  function automatic logic raise_busy();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (raise_seq[k] != served_seq[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic raise(input int k, input int v);
    @(negedge clk_1mhz);
    pend_data[k] = BIN_W'(v);
    raise_seq[k]++;
  endtask

  task automatic wait_quiet(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk_1mhz);
    while ((req_ip != '0 || raise_busy() || exp_q.size() != 0 || busy_op) && n < max_cyc) begin
      @(negedge clk_1mhz);
      n++;
    end
    chk("quiet_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic assert_reset_now(input string tag);
    reset_n_ip = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_ptr = 0;
    #1;
    chk({tag, "_ack"},   32'(ack_op),       32'd0);
    chk({tag, "_busy"},  32'(busy_op),      32'd0);
    chk({tag, "_valid"}, 32'(res_valid_op), 32'd0);
    chk({tag, "_id"},    32'(res_id_op),    32'd0);
    chk({tag, "_bcd"},   32'(bcd_data_op),  32'd0);
    chk({tag, "_state"}, 32'(state_dbg),    32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_1mhz);
    #200;
    reset_n_ip = 1'b1;
  endtask

  // watchdog
  initial begin
    #(60000 * 1000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int exp_order[5];
  int n;
  logic [BIN_W-1:0] v;

  initial begin
`ifdef BCD_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    #10;
    assert_reset_now("reset");
    release_reset();

    // single conversion, then ch2 boundary operands
    raise(0, 1234);  wait_quiet(100);
    raise(2, 8191);  wait_quiet(100);
    raise(2, 0);     wait_quiet(100);
    raise(2, 9);     wait_quiet(100);

    // operand changes right after capture
    @(negedge clk_1mhz);
    alt_data[3] = BIN_W'(777);
    alt_en[3]   = 1'b1;
    raise(3, 500);   wait_quiet(100);
    alt_en[3]   = 1'b0;

    // all requesters held: grant order
    @(negedge clk_1mhz);
    grant_log.delete();
    for (int k = 0; k < NUM_REQ; k++) begin
      pend_data[k] = BIN_W'(1000 + 1111 * k);
      raise_seq[k]++;
    end
    hold_mode = '1;
    n = 0;
    while (grant_log.size() < 5 && n < 120) begin
      @(negedge clk_1mhz);
      n++;
    end
    hold_mode = '0;
    chk("hold_grants", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("hold_order", grant_log[i], exp_order[i]);
    end
    wait_quiet(200);

    // reset in the sixth CONV cycle of a ch1 conversion
    raise(1, 4095);
    n = 0;
    while (!ack_op[1] && n < 20) begin
      @(negedge clk_1mhz);
      n++;
    end
    chk("abort_ack_seen", 32'(ack_op[1]), 32'd1);
    repeat (5) @(posedge clk_1mhz);
    #300;
    chk("abort_busy_before", 32'(busy_op), 32'd1);
    assert_reset_now("abort");
    release_reset();
    raise(1, 4095);  wait_quiet(100);

    // randomized traffic, operands scrambled after each capture
    alt_en = '1;
    repeat (400) begin
      @(negedge clk_1mhz);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_ip[k] && raise_seq[k] == served_seq[k] && $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            default: v = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
          endcase
          pend_data[k] = v;
          alt_data[k]  = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
          raise_seq[k]++;
        end
      end
    end
    wait_quiet(600);
    alt_en = '0;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
